// File: rtl/perf_snapshot_sampler.sv
// rtl/perf_snapshot_sampler.sv - Tear-free perf counter snapshot master feeding a framed record FIFO
module perf_snapshot_sampler #(
  parameter int NUM_SECTIONS    = 3,
  parameter int FIFO_DEPTH      = 16,
  parameter bit CLEAR_ON_SAMPLE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger,
  output logic [3:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy,
  output logic [15:0] drop_count
);
  localparam int SW        = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_WORDS = 3 * NUM_SECTIONS;
  localparam logic [SW-1:0] LAST_SEC = SW'(NUM_SECTIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_LO2, S_RD_EV, S_PUSH, S_CLEAR
  } state_t;

  state_t        state, state_n;
  logic          phase, phase_n;
  logic [SW-1:0] sec, sec_n;
  logic [1:0]    widx, widx_n;
  logic [31:0]   hi1, lo, hi2, ev;
  logic          pending, pending_n, drop_inc;
  logic          req, start, has_room, push, pop;
  logic [33:0]   push_word;
  logic [1:0]    addr_off;

  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;

  // Space for a whole record is reserved at admission, so PUSH never stalls.
  assign has_room = (FIFO_DEPTH - int'(fifo_count)) >= REC_WORDS;

  always_comb begin
    req       = trigger | pending;
    start     = 1'b0;
    pending_n = pending;
    drop_inc  = 1'b0;
    if (state == S_IDLE) begin
      if (req && has_room) begin
        start     = 1'b1;
        pending_n = trigger & pending;
      end else if (req) begin
        drop_inc  = 1'b1;
        pending_n = 1'b0;
      end
    end else if (trigger) begin
      if (pending) drop_inc = 1'b1;
      else         pending_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      sec        <= '0;
      widx       <= '0;
      pending    <= 1'b0;
      drop_count <= '0;
      hi1        <= '0;
      lo         <= '0;
      hi2        <= '0;
      ev         <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      sec     <= sec_n;
      widx    <= widx_n;
      pending <= pending_n;
      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (phase) begin
        unique case (state)
          S_RD_HI1: hi1 <= avm_readdata;
          S_RD_LO:  lo  <= avm_readdata;
          S_RD_HI2: hi2 <= avm_readdata;
          S_RD_LO2: lo  <= avm_readdata;
          S_RD_EV:  ev  <= avm_readdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    phase_n = 1'b0;
    sec_n   = sec;
    widx_n  = widx;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RD_HI1;
          sec_n   = '0;
        end
      end
      S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_LO2, S_RD_EV: begin
        phase_n = ~phase;
        if (phase) begin
          unique case (state)
            S_RD_HI1: state_n = S_RD_LO;
            S_RD_LO:  state_n = S_RD_HI2;
            // A changed high word means the low word may have wrapped: re-read it.
            S_RD_HI2: state_n = (avm_readdata != hi1) ? S_RD_LO2 : S_RD_EV;
            S_RD_LO2: state_n = S_RD_EV;
            default: begin
              state_n = S_PUSH;
              widx_n  = '0;
            end
          endcase
        end
      end
      S_PUSH: begin
        widx_n = widx + 2'd1;
        if (widx == 2'd2) begin
          widx_n = '0;
          if (sec == LAST_SEC) begin
            state_n = CLEAR_ON_SAMPLE ? S_CLEAR : S_IDLE;
          end else begin
            sec_n   = sec + SW'(1);
            state_n = S_RD_HI1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read          = 1'b0;
    avm_write         = 1'b0;
    avm_begintransfer = 1'b0;
    avm_writedata     = '0;
    avm_address       = '0;
    addr_off          = 2'd0;
    unique case (state)
      S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_LO2, S_RD_EV: begin
        if (state == S_RD_HI1 || state == S_RD_HI2) addr_off = 2'd1;
        else if (state == S_RD_EV)                  addr_off = 2'd2;
        avm_address       = 4'({sec, addr_off});
        avm_read          = ~phase;
        avm_begintransfer = ~phase;
      end
      S_CLEAR: begin
        avm_write         = 1'b1;
        avm_begintransfer = 1'b1;
        avm_writedata     = 32'h1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // FIFO word layout: {sop, eop, data}; hi2 equals hi1 whenever no retry happened.
  always_comb begin
    push_word = '0;
    unique case (widx)
      2'd0:    push_word = {sec == '0, 1'b0, lo};
      2'd1:    push_word = {2'b00, hi2};
      default: push_word = {1'b0, sec == LAST_SEC, ev};
    endcase
  end

  assign push      = (state == S_PUSH);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? fifo_mem[rd_ptr][31:0] : '0;
  assign out_sop  = out_valid & fifo_mem[rd_ptr][33];
  assign out_eop  = out_valid & fifo_mem[rd_ptr][32];

endmodule
